// File: rtl/moving_msg_scroller.sv
// Scrolls one of NUM_MSG externally supplied messages across a multiplexed,
// common-anode seven-segment display, with loop/one-shot modes and pause.
module moving_msg_scroller #(
    parameter int NUM_MSG     = 4,
    parameter int MSG_CHARS   = 16,
    parameter int DIGITS      = 8,
    parameter int SCROLL_DIV  = 100_000_000,
    parameter int REFRESH_DIV = 100_000,
    localparam int SEL_W      = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_MSG*MSG_CHARS*5-1:0] msg_flat,
    input  logic [SEL_W-1:0]               sel,
    input  logic                           sel_valid,
    input  logic                           mode,
    input  logic                           pause,
    output logic [DIGITS-1:0]              AN,
    output logic [6:0]                     seg,
    output logic                           done
);
    localparam int SCAN_CW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SCROLL_CW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int OFF_W     = (MSG_CHARS > 1) ? $clog2(MSG_CHARS) : 1;
    localparam int SUM_W     = OFF_W + 1;
    localparam int MSG_SLOTS = 1 << SEL_W;

    localparam logic [SCAN_CW-1:0]   SCAN_LAST   = SCAN_CW'(REFRESH_DIV - 1);
    localparam logic [SCROLL_CW-1:0] SCROLL_LAST = SCROLL_CW'(SCROLL_DIV - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST    = IDX_W'(DIGITS - 1);
    localparam logic [OFF_W-1:0]     OFF_LAST    = OFF_W'(MSG_CHARS - 1);
    localparam logic [OFF_W-1:0]     OFF_FINAL   = OFF_W'(MSG_CHARS - DIGITS);

    logic [SCAN_CW-1:0]   scan_cnt_reg;
    logic [IDX_W-1:0]     scan_idx_reg;
    logic [IDX_W-1:0]     disp_pos_reg, disp_pos_next;
    logic [SCROLL_CW-1:0] scroll_cnt_reg, scroll_cnt_next;
    logic [OFF_W-1:0]     offset_reg, offset_next;
    logic                 done_reg, done_next;
    logic [SEL_W-1:0]     prev_sel_reg;
    logic                 prev_act_reg, prev_mode_reg;
    logic [DIGITS-1:0]    an_reg, an_pat;
    logic [6:0]           seg_reg;
    logic                 act, restart, scan_tick;
    logic [SUM_W-1:0]     char_sum;
    logic [OFF_W-1:0]     char_idx;
    logic [4:0]           cur_char;
    logic [4:0]           chars [MSG_SLOTS][MSG_CHARS];

    // Unpopulated select slots read as blank glyphs so any sel value is safe to index.
    for (genvar gi = 0; gi < MSG_SLOTS; gi++) begin : g_msg
        for (genvar gj = 0; gj < MSG_CHARS; gj++) begin : g_chr
            if (gi < NUM_MSG) begin : g_real
                assign chars[gi][gj] = msg_flat[(gi*MSG_CHARS+gj)*5 +: 5];
            end else begin : g_pad
                assign chars[gi][gj] = 5'd31;
            end
        end
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_an
        assign an_pat[gi] = (scan_idx_reg != IDX_W'(DIGITS - 1 - gi));
    end

    assign act       = sel_valid && (int'(sel) < NUM_MSG);
    assign restart   = (sel != prev_sel_reg) || (act && !prev_act_reg) || (mode != prev_mode_reg);
    assign scan_tick = (scan_cnt_reg == SCAN_LAST);

    function automatic logic [6:0] glyph(input logic [4:0] c);
        case (c)
            5'd0:  glyph = 7'h40;  5'd1:  glyph = 7'h79;  5'd2:  glyph = 7'h24;
            5'd3:  glyph = 7'h30;  5'd4:  glyph = 7'h19;  5'd5:  glyph = 7'h12;
            5'd6:  glyph = 7'h02;  5'd7:  glyph = 7'h78;  5'd8:  glyph = 7'h00;
            5'd9:  glyph = 7'h10;  5'd10: glyph = 7'h08;  5'd11: glyph = 7'h03;
            5'd12: glyph = 7'h46;  5'd13: glyph = 7'h21;  5'd14: glyph = 7'h06;
            5'd15: glyph = 7'h0E;  5'd16: glyph = 7'h09;  5'd17: glyph = 7'h47;
            5'd18: glyph = 7'h2B;  5'd19: glyph = 7'h23;  5'd20: glyph = 7'h0C;
            5'd21: glyph = 7'h2F;  5'd22: glyph = 7'h07;  5'd23: glyph = 7'h41;
            5'd24: glyph = 7'h11;  5'd25: glyph = 7'h3F;  5'd26: glyph = 7'h77;
            default: glyph = 7'h7F;
        endcase
    endfunction

    // Offset/done/prescaler: restart dominates, then a paused or blanked panel freezes.
    always_comb begin
        scroll_cnt_next = scroll_cnt_reg;
        offset_next     = offset_reg;
        done_next       = done_reg;
        if (restart) begin
            scroll_cnt_next = '0;
            offset_next     = '0;
            done_next       = 1'b0;
        end else if (act) begin
            done_next = mode && (offset_reg == OFF_FINAL);
            if (!pause) begin
                if (scroll_cnt_reg == SCROLL_LAST) begin
                    scroll_cnt_next = '0;
                    if (!mode) begin
                        offset_next = (offset_reg == OFF_LAST) ? '0 : offset_reg + 1'b1;
                    end else if (offset_reg != OFF_FINAL) begin
                        offset_next = offset_reg + 1'b1;
                    end
                end else begin
                    scroll_cnt_next = scroll_cnt_reg + 1'b1;
                end
            end
        end
    end

    // The lit digit latches the pre-increment scan index, so position 0 shows first.
    always_comb begin
        disp_pos_next = scan_tick ? scan_idx_reg : disp_pos_reg;
        char_sum      = {1'b0, offset_reg} + SUM_W'(disp_pos_next);
        char_idx      = (char_sum >= SUM_W'(MSG_CHARS)) ? OFF_W'(char_sum - SUM_W'(MSG_CHARS))
                                                        : OFF_W'(char_sum);
        cur_char      = chars[sel][char_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_reg   <= '0;
            scan_idx_reg   <= '0;
            disp_pos_reg   <= '0;
            scroll_cnt_reg <= '0;
            offset_reg     <= '0;
            done_reg       <= 1'b0;
            prev_sel_reg   <= '0;
            prev_act_reg   <= 1'b0;
            prev_mode_reg  <= 1'b0;
            an_reg         <= '1;
            seg_reg        <= 7'h7F;
        end else begin
            if (scan_tick) begin
                scan_cnt_reg <= '0;
                scan_idx_reg <= (scan_idx_reg == IDX_LAST) ? '0 : scan_idx_reg + 1'b1;
            end else begin
                scan_cnt_reg <= scan_cnt_reg + 1'b1;
            end
            disp_pos_reg   <= disp_pos_next;
            scroll_cnt_reg <= scroll_cnt_next;
            offset_reg     <= offset_next;
            done_reg       <= done_next;
            prev_sel_reg   <= sel;
            prev_act_reg   <= act;
            prev_mode_reg  <= mode;
            if (!act) begin
                an_reg  <= '1;
                seg_reg <= 7'h7F;
            end else begin
                if (scan_tick) an_reg <= an_pat;
                seg_reg <= glyph(cur_char);
            end
        end
    end

    assign AN   = an_reg;
    assign seg  = seg_reg;
    assign done = done_reg;
endmodule
